ff_multi_squarer: RTL and testbench

//  Sequential GF(2^M) repeated squarer: computes c = a^(2^n) in polynomial basis.

---
 rtl/ff_pkg.sv | 20 ++
 rtl/ff_square_step.sv | 41 ++++
 rtl/ff_multi_squarer.sv | 67 ++++++
 tb/tb_ff_multi_squarer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// ff_pkg: GF(2^M) field defaults and a generic polynomial-basis squaring function
package ff_pkg;
   localparam int                FF_M     = 163;
   localparam logic [FF_M-1:0]   FF_POLY  = 163'hC9;
   localparam int                FF_CNT_W = 8;
   localparam int                FF_K     = 1;

   // x^2 mod (x^M + POLY): spread bits, then fold the upper half back top-down
   function automatic logic [FF_M-1:0] gf_square(input logic [FF_M-1:0] x);
      logic [2*FF_M-2:0] t;
      t = '0;
      for (int i = 0; i < FF_M; i++) t[2*i] = x[i];
      for (int j = 2*FF_M-2; j >= FF_M; j--)
         if (t[j]) begin
            t    = t ^ ({{(FF_M-1){1'b0}}, FF_POLY} << (j - FF_M));
            t[j] = 1'b0;
         end
      return t[FF_M-1:0];
   endfunction
endpackage

// File: rtl/ff_square_step.sv
// ff_square_step: K cascaded GF(2^M) squarers; tap min(K, rem) selects how many are applied
module ff_square_step #(
   parameter int             M     = ff_pkg::FF_M,
   parameter logic [M-1:0]   POLY  = ff_pkg::FF_POLY,
   parameter int             K     = ff_pkg::FF_K,
   parameter int             CNT_W = ff_pkg::FF_CNT_W
) (
   input  logic [M-1:0]     i_x,
   input  logic [CNT_W-1:0] i_rem,
   output logic [M-1:0]     o_y
);
   function automatic logic [M-1:0] sq(input logic [M-1:0] x);
      logic [2*M-2:0] t;
      t = '0;
      for (int i = 0; i < M; i++) t[2*i] = x[i];
      for (int j = 2*M-2; j >= M; j--)
         if (t[j]) begin
            t    = t ^ ({{(M-1){1'b0}}, POLY} << (j - M));
            t[j] = 1'b0;
         end
      return t[M-1:0];
   endfunction

   logic [M-1:0] w_stage [K+1];
   logic [M-1:0] w_y;

   assign w_stage[0] = i_x;

   for (genvar g = 0; g < K; g++) begin : g_sq
      assign w_stage[g+1] = sq(w_stage[g]);
   end

   // rem >= K takes the full chain; smaller rem takes an earlier tap so we never over-square
   always_comb begin
      w_y = w_stage[K];
      for (int i = 1; i < K; i++)
         if (i_rem == CNT_W'(i)) w_y = w_stage[i];
   end

   assign o_y = w_y;
endmodule

// File: rtl/ff_multi_squarer.sv
// ff_multi_squarer: sequential GF(2^M) repeated squarer, c = a^(2^n), K squarings per clock
import ff_pkg::*;

module ff_multi_squarer #(
   parameter int             M            = FF_M,
   parameter logic [M-1:0]   POLY         = FF_POLY,
   parameter int             SQ_PER_CYCLE = FF_K,
   parameter int             CNT_W        = FF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [M-1:0]     a,
   input  logic [CNT_W-1:0] n,
   output logic             ready,
   output logic             done,
   output logic [M-1:0]     c
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [CNT_W-1:0] K_W = CNT_W'(SQ_PER_CYCLE);

   logic [1:0]       r_state;
   logic [M-1:0]     r_acc;
   logic [CNT_W-1:0] r_rem;
   logic [M-1:0]     w_next;
   logic [CNT_W-1:0] w_step;

   assign w_step = (r_rem >= K_W) ? K_W : r_rem;

   ff_square_step #(
      .M     (M),
      .POLY  (POLY),
      .K     (SQ_PER_CYCLE),
      .CNT_W (CNT_W)
   ) u_step (
      .i_x   (r_acc),
      .i_rem (r_rem),
      .o_y   (w_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_rem   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_acc   <= a;
               r_rem   <= n;
               r_state <= S_RUN;
            end
            S_RUN: if (r_rem != '0) begin
               r_acc <= w_next;
               r_rem <= r_rem - w_step;
            end else r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready = (r_state == S_IDLE);
   assign done  = (r_state == S_DONE);
   assign c     = r_acc;
endmodule

// File: tb/tb_ff_multi_squarer.sv
// tb_ff_multi_squarer: checks K=1 and K=4 instances against a shift-and-reduce multiply model
module tb_ff_multi_squarer;
   localparam logic [162:0] P = 163'hC9;

   typedef struct {
      logic [162:0] a;
      int           n;
      logic [162:0] c;
      string        name;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   start = 2'b00;
   logic [162:0] a = '0;
   logic [7:0]   n = '0;
   logic [1:0]   ready, done;
   logic [162:0] c0, c1;
   int           checks = 0;
   int           errors = 0;
   vec_t         tbl[4];

   always #5 clk = ~clk;

   ff_multi_squarer #(.SQ_PER_CYCLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start[0]), .a(a), .n(n),
      .ready(ready[0]), .done(done[0]), .c(c0));

   ff_multi_squarer #(.SQ_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .start(start[1]), .a(a), .n(n),
      .ready(ready[1]), .done(done[1]), .c(c1));

   function automatic logic [162:0] gf_mul(input logic [162:0] x, input logic [162:0] y);
      logic [162:0] r, b;
      logic         hi;
      r = '0;
      b = x;
      for (int i = 0; i < 163; i++) begin
         if (y[i]) r = r ^ b;
         hi = b[162];
         b  = b << 1;
         if (hi) b = b ^ P;
      end
      return r;
   endfunction

   function automatic logic [162:0] pow2n(input logic [162:0] x, input int cnt);
      logic [162:0] r;
      r = x;
      for (int i = 0; i < cnt; i++) r = gf_mul(r, r);
      return r;
   endfunction

   function automatic logic [162:0] rand163();
      logic [162:0] r;
      for (int i = 0; i < 6; i++) r = {r[130:0], 32'($urandom)};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int d, input logic [162:0] got, input logic [162:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (K=%0d): got %h expected %h", nm, d ? 4 : 1, got, exp);
      end
   endtask

   function automatic logic [162:0] cval(input int d);
      return d ? c1 : c0;
   endfunction

   task automatic run_op(input int d, input logic [162:0] av, input int nv,
                         input logic [162:0] ec, input string nm, input bit hold);
      int k, lat, w;
      k = d ? 4 : 1;
      w = 0;
      while (!ready[d] && w < 50) begin tick(); w++; end
      chk({nm, " ready before start"}, d, 163'(ready[d]), 163'd1);
      a = av;
      n = nv[7:0];
      start[d] = 1'b1;
      tick();
      if (hold) begin
         a = ~av;
         n = 8'd1;
      end else start[d] = 1'b0;
      lat = 0;
      while (!done[d] && lat < 400) begin tick(); lat++; end
      chk({nm, " latency"}, d, 163'(lat), 163'((nv + k - 1) / k + 1));
      chk({nm, " c"}, d, cval(d), ec);
      tick();
      if (hold) begin
         start[d] = 1'b0;
         chk({nm, " ready after done"}, d, 163'(ready[d]), 163'd1);
         chk({nm, " c held"}, d, cval(d), ec);
      end
   endtask

   initial begin
      logic [162:0] ra;
      int           rn;
      tbl[0] = '{163'd1, 5, 163'd1, "one^32"};
      tbl[1] = '{163'd2, 1, 163'd4, "x squared"};
      tbl[2] = '{163'd1 << 162, 1,
                 (163'd1 << 161) | (163'd1 << 12) | (163'd1 << 10) | (163'd1 << 5) | 163'd2,
                 "x162 squared"};
      ra = rand163();
      tbl[3] = '{ra, 163, ra, "fermat"};

      repeat (3) tick();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("reset ready", d, 163'(ready[d]), 163'd1);
         chk("reset done", d, 163'(done[d]), 163'd0);
         chk("reset c", d, cval(d), 163'd0);
      end

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4; i++) run_op(d, tbl[i].a, tbl[i].n, tbl[i].c, tbl[i].name, 1'b0);

      for (int d = 0; d < 2; d++) begin
         ra = rand163();
         run_op(d, ra, 0, ra, "n0 with ignored starts", 1'b1);
         ra = rand163();
         run_op(d, ra, 10, pow2n(ra, 10), "n10 with ignored starts", 1'b1);
         ra = rand163();
         run_op(d, ra, 255, pow2n(ra, 255), "n255 max count", 1'b0);
      end

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 12; i++) begin
            ra = rand163();
            rn = int'($urandom_range(0, 40));
            run_op(d, ra, rn, pow2n(ra, rn), "random", 1'b0);
         end

      for (int d = 0; d < 2; d++) begin
         a = rand163();
         n = 8'd100;
         start[d] = 1'b1;
         tick();
         start[d] = 1'b0;
         repeat (10) tick();
         rst = 1'b1;
         tick();
         rst = 1'b0;
         chk("mid-run reset ready", d, 163'(ready[d]), 163'd1);
         chk("mid-run reset done", d, 163'(done[d]), 163'd0);
         chk("mid-run reset c", d, cval(d), 163'd0);
         run_op(d, 163'd1, 3, 163'd1, "after reset", 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
